// File: rtl/alu_muldiv_seq.sv
// Sequential RV64M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Optional macro ALU_MUL_FAST_EN: MUL* use a single combinational multiplier and finish one edge after accept.
module alu_muldiv_seq #(
  parameter int XLEN = 64,
  parameter int OPW  = 3
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [OPW-1:0]  i_Op,
  input  logic [XLEN-1:0] i_Rs1,
  input  logic [XLEN-1:0] i_Rs2,
  input  logic            i_Flush,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Zero
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [OPW-1:0]    op_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg, b_reg;
  logic              neg_reg, rneg_reg;
  logic [CW-1:0]     count_reg;
  logic [XLEN-1:0]   result_reg;
  logic              zero_reg, ready_reg, valid_reg;

  // Accept-side decode: operand signedness, magnitudes and the no-iteration divide cases
  logic              is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_result;
  logic              mul_fast;
  logic [2*XLEN-1:0] fast_prod, fast_prod_s;
  logic [XLEN-1:0]   fast_result;

  always_comb begin
    is_div   = i_Op[2];
    a_sgn    = is_div ? ~i_Op[0] : (i_Op[1:0] != 2'd3);
    b_sgn    = is_div ? ~i_Op[0] : ~i_Op[1];
    a_neg    = a_sgn & i_Rs1[XLEN-1];
    b_neg    = b_sgn & i_Rs2[XLEN-1];
    a_mag    = a_neg ? -i_Rs1 : i_Rs1;
    b_mag    = b_neg ? -i_Rs2 : i_Rs2;
    div_zero = is_div & (i_Rs2 == '0);
    div_ovf  = is_div & ~i_Op[0] & (i_Rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_Rs2);
    if (div_zero)
      special_result = i_Op[1] ? i_Rs1 : '1;
    else
      special_result = i_Op[1] ? '0 : i_Rs1;
`ifdef ALU_MUL_FAST_EN
    fast_prod = a_mag * b_mag;
    mul_fast  = ~is_div;
`else
    fast_prod = '0;
    mul_fast  = 1'b0;
`endif
    fast_prod_s = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    fast_result = (i_Op[1:0] == 2'd0) ? fast_prod_s[XLEN-1:0] : fast_prod_s[2*XLEN-1:XLEN];
  end

  // One iteration step; multiply and divide share the hi/lo/b registers
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   hi_sh, diff, hi_next, lo_next;
  logic              ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, iter_result;

  always_comb begin
    sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    hi_sh = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
    diff  = hi_sh - b_reg;
    ge    = {hi_reg[XLEN-1], hi_sh} >= {1'b0, b_reg};
    if (op_reg[2]) begin
      hi_next = ge ? diff : hi_sh;
      lo_next = {lo_reg[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo_reg[XLEN-1:1]};
    end
    prod   = {hi_next, lo_next};
    prod_s = neg_reg ? -prod : prod;
    quo    = neg_reg ? -lo_next : lo_next;
    rem    = rneg_reg ? -hi_next : hi_next;
    if (op_reg[2])
      iter_result = op_reg[1] ? rem : quo;
    else
      iter_result = (op_reg[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      op_reg     <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      neg_reg    <= 1'b0;
      rneg_reg   <= 1'b0;
      count_reg  <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Valid && !i_Flush) begin
            op_reg    <= i_Op;
            neg_reg   <= a_neg ^ b_neg;
            rneg_reg  <= a_neg;
            hi_reg    <= '0;
            lo_reg    <= is_div ? a_mag : b_mag;
            b_reg     <= is_div ? b_mag : a_mag;
            count_reg <= '0;
            ready_reg <= 1'b0;
            if (div_zero || div_ovf) begin
              result_reg <= special_result;
              zero_reg   <= (special_result == '0);
              valid_reg  <= 1'b1;
              state      <= DONE;
            end else if (mul_fast) begin
              result_reg <= fast_result;
              zero_reg   <= (fast_result == '0);
              valid_reg  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_Flush) begin
            state     <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            count_reg <= count_reg + 1'b1;
            if (count_reg == CW'(XLEN-1)) begin
              result_reg <= iter_result;
              zero_reg   <= (iter_result == '0);
              valid_reg  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          // Flush and hand-off both return to IDLE; the result is simply dropped on flush
          if (i_Flush || i_Ready) begin
            state     <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_Ready  = ready_reg;
  assign o_Valid  = valid_reg;
  assign o_Result = result_reg;
  assign o_Zero   = zero_reg;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed checks of alu_muldiv_seq against a plain-arithmetic reference model.
// Honours ALU_MUL_FAST_EN for the expected MUL* latency.
module tb_alu_muldiv_seq;

  localparam int XLEN = 64;
`ifdef ALU_MUL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic        i_Clk = 1'b0, i_Rst_n = 1'b0, i_Valid = 1'b0, i_Flush = 1'b0, i_Ready = 1'b0;
  logic [2:0]  i_Op = '0;
  logic [63:0] i_Rs1 = '0, i_Rs2 = '0;
  logic        o_Ready, o_Valid, o_Zero;
  logic [63:0] o_Result;

  int errors = 0;
  int checks = 0;

  alu_muldiv_seq #(.XLEN(XLEN), .OPW(3)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Op(i_Op), .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .i_Flush(i_Flush),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Result(o_Result), .o_Zero(o_Zero)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, ua, ub, p;
    logic [63:0] r;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'b0, a};
    ub = {64'b0, b};
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[63:0];   end
      3'd1: begin p = sa * sb; r = p[127:64]; end
      3'd2: begin p = sa * ub; r = p[127:64]; end
      3'd3: begin p = ua * ub; r = p[127:64]; end
      3'd4: r = (b == 0) ? '1 : ((a == MIN && b == '1) ? a : 64'($signed(a) / $signed(b)));
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: r = (b == 0) ? a  : ((a == MIN && b == '1) ? '0 : 64'($signed(a) % $signed(b)));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MIN && b == '1))) return 1;
    if (!op[2] && FAST) return 1;
    return XLEN + 1;
  endfunction

  // Issue one op, count edges (accept edge included) until o_Valid; optionally hand the result off.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit handoff);
    int edges;
    logic [63:0] exp;
    exp = ref_result(op, a, b);
    chk({tag, " ready_in"}, 64'(o_Ready), 64'd1);
    i_Valid = 1'b1; i_Op = op; i_Rs1 = a; i_Rs2 = b;
    edges = 0;
    do begin
      @(posedge i_Clk); #1;
      edges++;
      i_Valid = 1'b0;
      i_Op = 3'($urandom); i_Rs1 = {$urandom, $urandom}; i_Rs2 = {$urandom, $urandom};
    end while (!o_Valid && edges < 200);
    chk({tag, " latency"}, 64'(edges), 64'(ref_latency(op, a, b)));
    chk({tag, " result"}, o_Result, exp);
    chk({tag, " zero"}, 64'(o_Zero), 64'(exp == 0));
    $display("op=%0d a=%h b=%h -> %h zero=%0b edges=%0d", op, a, b, o_Result, o_Zero, edges);
    if (handoff) begin
      i_Ready = 1'b1;
      @(posedge i_Clk); #1;
      i_Ready = 1'b0;
      chk({tag, " valid_after"}, 64'(o_Valid), 64'd0);
      chk({tag, " ready_after"}, 64'(o_Ready), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] a, b, held;
    logic [2:0]  op;
    bit          saw_valid;

    repeat (2) @(posedge i_Clk);
    #1;
    chk("rst ready", 64'(o_Ready), 64'd1);
    chk("rst valid", 64'(o_Valid), 64'd0);
    chk("rst result", o_Result, 64'd0);
    chk("rst zero", 64'(o_Zero), 64'd0);
    i_Rst_n = 1'b1;

    run_op("mul", 3'd0, 64'd7, -64'sd3, 1'b1);
    run_op("mulhu", 3'd3, '1, '1, 1'b1);
    run_op("mulh", 3'd1, '1, '1, 1'b1);
    run_op("mulhsu", 3'd2, '1, '1, 1'b1);
    run_op("div", 3'd4, -64'sd7, 64'd2, 1'b1);
    run_op("rem", 3'd6, -64'sd7, 64'd2, 1'b1);
    run_op("divu", 3'd5, 64'd100, 64'd7, 1'b1);
    run_op("remu", 3'd7, 64'd100, 64'd7, 1'b1);
    run_op("div0", 3'd4, 64'd5, 64'd0, 1'b1);
    run_op("rem0", 3'd6, 64'd5, 64'd0, 1'b1);
    run_op("divovf", 3'd4, MIN, '1, 1'b1);
    run_op("removf", 3'd6, MIN, '1, 1'b1);
    run_op("divuovf", 3'd5, MIN, '1, 1'b1);

    // Hold the result in DONE with no consumer
    run_op("hold", 3'd5, 64'd1000, 64'd9, 1'b0);
    held = o_Result;
    repeat (10) begin
      @(posedge i_Clk); #1;
      chk("hold valid", 64'(o_Valid), 64'd1);
      chk("hold result", o_Result, held);
      chk("hold ready", 64'(o_Ready), 64'd0);
    end
    i_Ready = 1'b1; @(posedge i_Clk); #1; i_Ready = 1'b0;
    chk("hold released", 64'(o_Valid), 64'd0);

    // Flush while IDLE blocks the accept
    i_Valid = 1'b1; i_Flush = 1'b1; i_Op = 3'd0; i_Rs1 = 64'd3; i_Rs2 = 64'd4;
    @(posedge i_Clk); #1;
    i_Valid = 1'b0; i_Flush = 1'b0;
    chk("idle flush ready", 64'(o_Ready), 64'd1);

    // Flush part-way through a divide
    i_Valid = 1'b1; i_Op = 3'd4; i_Rs1 = 64'd12345; i_Rs2 = 64'd17;
    @(posedge i_Clk); #1;
    i_Valid = 1'b0;
    repeat (19) @(posedge i_Clk);
    #1;
    chk("busy ready", 64'(o_Ready), 64'd0);
    i_Flush = 1'b1;
    @(posedge i_Clk); #1;
    i_Flush = 1'b0;
    chk("flush ready", 64'(o_Ready), 64'd1);
    saw_valid = 1'b0;
    repeat (70) begin @(posedge i_Clk); #1; if (o_Valid) saw_valid = 1'b1; end
    chk("flush no valid", 64'(saw_valid), 64'd0);

    // Reset pulse mid-operation
    i_Valid = 1'b1; i_Op = 3'd7; i_Rs1 = 64'd999; i_Rs2 = 64'd10;
    @(posedge i_Clk); #1;
    i_Valid = 1'b0;
    repeat (10) @(posedge i_Clk);
    #1;
    i_Rst_n = 1'b0;
    @(posedge i_Clk); #1;
    i_Rst_n = 1'b1;
    chk("midrst ready", 64'(o_Ready), 64'd1);
    chk("midrst valid", 64'(o_Valid), 64'd0);
    chk("midrst result", o_Result, 64'd0);
    saw_valid = 1'b0;
    repeat (70) begin @(posedge i_Clk); #1; if (o_Valid) saw_valid = 1'b1; end
    chk("midrst no valid", 64'(saw_valid), 64'd0);
    run_op("after rst", 3'd6, -64'sd100, 64'd7, 1'b1);

    // Randomized ops including the special divide cases
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = MIN; b = '1; end
        2: begin a = 64'($signed(32'($urandom_range(0, 2000)) - 32'sd1000)); b = 64'($urandom_range(1, 50)); end
        3: b = 64'($urandom);
        default: ;
      endcase
      run_op("rand", op, a, b, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
